// File: rtl/pc_word_serializer_rr.sv
// ---------------------------------------------------------------------------
// pc_word_serializer_rr
//
// Round-robin multi-channel serializer toward the PC link. Each accepted input
// word is split into NPCdata-bit chunks (LSB first, zero padded above NInData)
// and every chunk is tagged with ChanCodeBase + chan*NChunk + chunk. Heartbeat
// (HB) time words take priority at word boundaries and go out as an MSB/LSB
// pair (codes HBCodeMsb / HBCodeLsb).
//
// Optional feature macro: PC_SER_HB_MSB_ELIDE_EN
//   When defined, the HB MSB word is skipped if its value matches the last MSB
//   actually sent since reset.
//
// Ports:
//   clk              in   clock, all logic on posedge
//   reset            in   synchronous active-high reset
//   send_HB_up_pulse in   one-cycle HB request
//   time_elapsed     in   wall time, captured on the pulse
//   in_v             in   per-channel valid
//   in_d             in   channel i data at [i*NInData +: NInData]
//   in_a             out  per-channel ack (combinational, one-hot or zero)
//   pc_v             out  output valid (registered)
//   pc_code          out  output code (registered)
//   pc_payload       out  output payload (registered)
//   pc_a             in   output ack from the sink
// ---------------------------------------------------------------------------
module pc_word_serializer_rr #(
  parameter int                 NPCcode      = 8,
  parameter int                 NPCdata      = 24,
  parameter int                 Ntime        = 48,
  parameter int                 NChan        = 4,
  parameter int                 NInData      = 37,
  parameter logic [NPCcode-1:0] HBCodeLsb    = 8'd0,
  parameter logic [NPCcode-1:0] HBCodeMsb    = 8'd1,
  parameter logic [NPCcode-1:0] ChanCodeBase = 8'd2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     send_HB_up_pulse,
  input  logic [Ntime-1:0]         time_elapsed,
  input  logic [NChan-1:0]         in_v,
  input  logic [NChan*NInData-1:0] in_d,
  output logic [NChan-1:0]         in_a,
  output logic                     pc_v,
  output logic [NPCcode-1:0]       pc_code,
  output logic [NPCdata-1:0]       pc_payload,
  input  logic                     pc_a
);

  localparam int NChunk = (NInData + NPCdata - 1) / NPCdata;
  localparam int PW     = (NChan  > 1) ? $clog2(NChan)  : 1;
  localparam int CW     = (NChunk > 1) ? $clog2(NChunk) : 1;
  localparam int PadW   = NChunk * NPCdata;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_HB_MSB = 2'd2,
    ST_HB_LSB = 2'd3
  } state_t;

  // Chunk j of a word, zero padded above NInData.
  function automatic logic [NPCdata-1:0] chunk_of(input logic [NInData-1:0] w, input int j);
    logic [PadW-1:0] p;
    p              = '0;
    p[NInData-1:0] = w;
    return p[j*NPCdata +: NPCdata];
  endfunction

  // Code tag for chunk j of channel ch.
  function automatic logic [NPCcode-1:0] code_of(input int ch, input int j);
    int c;
    c = int'(ChanCodeBase) + ch * NChunk + j;
    return c[NPCcode-1:0];
  endfunction

  // state_q describes the word whose chunk/half currently sits in the output register
  state_t              state_q;
  logic [CW-1:0]       chunk_idx_q;
  logic [PW-1:0]       chan_q;
  logic [NInData-1:0]  data_q;
  logic [PW-1:0]       rr_ptr_q;
  logic                hb_pending_q;
  logic [Ntime-1:0]    hb_time_q;
  // A pulse arriving while an HB is being sent is parked here until it completes
  logic                held_v_q;
  logic [Ntime-1:0]    held_time_q;
  logic                pc_v_q;
  logic [NPCcode-1:0]  pc_code_q;
  logic [NPCdata-1:0]  pc_payload_q;
`ifdef PC_SER_HB_MSB_ELIDE_EN
  logic [NPCdata-1:0]  last_msb_q;
  logic                last_msb_v_q;
`endif

  logic                adv_s;
  logic                last_s;
  logic                arb_s;
  logic                sel_found_s;
  logic [PW-1:0]       sel_s;
  logic [PW-1:0]       rr_next_s;
  logic [NInData-1:0]  sel_data_s;
  logic                elide_s;
  logic                msb_start_s;
  logic                lsb_load_s;
  logic                data_start_s;

  // The output register can take a new word when empty or being consumed
  assign adv_s  = !pc_v_q || pc_a;
  assign last_s = (state_q == ST_IDLE) || (state_q == ST_HB_LSB) ||
                  ((state_q == ST_DATA) && (chunk_idx_q == CW'(NChunk - 1)));
  assign arb_s  = adv_s && last_s;

  // Round-robin search: first valid channel at or above rr_ptr_q, with wrap
  always_comb begin
    sel_found_s = 1'b0;
    sel_s       = rr_ptr_q;
    for (int k = 0; k < NChan; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NChan;
      if (!sel_found_s && in_v[idx]) begin
        sel_found_s = 1'b1;
        sel_s       = PW'(idx);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Pointer advances to the channel after the winner
  always_comb begin
    if (int'(sel_s) == NChan - 1) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = sel_s + PW'(1);
    end
  end

  assign sel_data_s = in_d[int'(sel_s)*NInData +: NInData];

`ifdef PC_SER_HB_MSB_ELIDE_EN
  assign elide_s = last_msb_v_q && (hb_time_q[Ntime-1:NPCdata] == last_msb_q);
`else
  assign elide_s = 1'b0;
`endif

  assign msb_start_s  = arb_s && hb_pending_q && !elide_s;
  // The LSB half is loaded either after the MSB or directly when the MSB is elided
  assign lsb_load_s   = adv_s && ((state_q == ST_HB_MSB) || (arb_s && hb_pending_q && elide_s));
  assign data_start_s = arb_s && !hb_pending_q && sel_found_s;

  // Ack the winning channel in the cycle its word is latched
  always_comb begin
    in_a = '0;
    if (data_start_s) begin
      in_a[sel_s] = 1'b1;
    end else begin
      in_a = '0;
    end
  end

  // HB capture, arbitration FSM and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      chunk_idx_q  <= '0;
      chan_q       <= '0;
      data_q       <= '0;
      rr_ptr_q     <= '0;
      hb_pending_q <= 1'b0;
      hb_time_q    <= '0;
      held_v_q     <= 1'b0;
      held_time_q  <= '0;
      pc_v_q       <= 1'b0;
      pc_code_q    <= '0;
      pc_payload_q <= '0;
`ifdef PC_SER_HB_MSB_ELIDE_EN
      last_msb_q   <= '0;
      last_msb_v_q <= 1'b0;
`endif
    end else begin
      // HB request bookkeeping; hb_time_q must stay stable between MSB and LSB
      if (lsb_load_s) begin
        if (send_HB_up_pulse) begin
          hb_time_q    <= time_elapsed;
          hb_pending_q <= 1'b1;
          held_v_q     <= 1'b0;
        end else if (held_v_q) begin
          hb_time_q    <= held_time_q;
          hb_pending_q <= 1'b1;
          held_v_q     <= 1'b0;
        end else begin
          hb_pending_q <= 1'b0;
        end
      end else if (send_HB_up_pulse) begin
        if (msb_start_s || (state_q == ST_HB_MSB)) begin
          held_v_q    <= 1'b1;
          held_time_q <= time_elapsed;
        end else begin
          hb_time_q    <= time_elapsed;
          hb_pending_q <= 1'b1;
        end
      end

      if (adv_s) begin
        if (arb_s) begin
          if (hb_pending_q) begin
            pc_v_q <= 1'b1;
            if (elide_s) begin
              state_q      <= ST_HB_LSB;
              pc_code_q    <= HBCodeLsb;
              pc_payload_q <= hb_time_q[NPCdata-1:0];
            end else begin
              state_q      <= ST_HB_MSB;
              pc_code_q    <= HBCodeMsb;
              pc_payload_q <= hb_time_q[Ntime-1:NPCdata];
`ifdef PC_SER_HB_MSB_ELIDE_EN
              last_msb_q   <= hb_time_q[Ntime-1:NPCdata];
              last_msb_v_q <= 1'b1;
`endif
            end
          end else if (sel_found_s) begin
            state_q      <= ST_DATA;
            chunk_idx_q  <= '0;
            chan_q       <= sel_s;
            data_q       <= sel_data_s;
            rr_ptr_q     <= rr_next_s;
            pc_v_q       <= 1'b1;
            pc_code_q    <= code_of(int'(sel_s), 0);
            pc_payload_q <= chunk_of(sel_data_s, 0);
          end else begin
            state_q <= ST_IDLE;
            pc_v_q  <= 1'b0;
          end
        end else begin
          case (state_q)
            ST_DATA: begin
              chunk_idx_q  <= chunk_idx_q + CW'(1);
              pc_v_q       <= 1'b1;
              pc_code_q    <= code_of(int'(chan_q), int'(chunk_idx_q) + 1);
              pc_payload_q <= chunk_of(data_q, int'(chunk_idx_q) + 1);
            end
            ST_HB_MSB: begin
              state_q      <= ST_HB_LSB;
              pc_v_q       <= 1'b1;
              pc_code_q    <= HBCodeLsb;
              pc_payload_q <= hb_time_q[NPCdata-1:0];
            end
            default: begin
              state_q <= ST_IDLE;
              pc_v_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign pc_v       = pc_v_q;
  assign pc_code    = pc_code_q;
  assign pc_payload = pc_payload_q;

endmodule

// File: tb/tb_pc_word_serializer_rr.sv
// Scoreboard bench for pc_word_serializer_rr (default parameters).
// Stimulus pushes hand-computed (code, payload) pairs; the monitor pops and
// compares on every output handshake.
module tb_pc_word_serializer_rr;

  logic          clk = 1'b0;
  logic          reset;
  logic          send_HB_up_pulse;
  logic [47:0]   time_elapsed;
  logic [3:0]    in_v;
  logic [147:0]  in_d;
  logic [3:0]    in_a;
  logic          pc_v;
  logic [7:0]    pc_code;
  logic [23:0]   pc_payload;
  logic          pc_a;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  pc_word_serializer_rr dut (
    .clk(clk), .reset(reset), .send_HB_up_pulse(send_HB_up_pulse),
    .time_elapsed(time_elapsed), .in_v(in_v), .in_d(in_d), .in_a(in_a),
    .pc_v(pc_v), .pc_code(pc_code), .pc_payload(pc_payload), .pc_a(pc_a)
  );

  // Monitor: compare every output handshake against the scoreboard
  always @(negedge clk) begin
    if (!reset && pc_v && pc_a) begin
      logic [31:0] exp_w;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got code=%0h payload=%06h, required no word", pc_code, pc_payload);
      end else begin
        exp_w = sb.pop_front();
        if ({pc_code, pc_payload} !== exp_w) begin
          errors++;
          $display("FAIL sb_word: got code=%0h payload=%06h, required code=%0h payload=%06h",
                   pc_code, pc_payload, exp_w[31:24], exp_w[23:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] c, input logic [23:0] p);
    sb.push_back({c, p});
  endtask

  task automatic set_ch(input int i, input logic [36:0] v);
    in_d[i*37 +: 37] = v;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Wait (bounded) for a given ack pattern at a negedge
  task automatic wait_ack(input logic [3:0] mask, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_a == mask) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: ack %0h never seen, last in_a=%0h", name, mask, in_a);
    end
  endtask

  // Wait (bounded) until all expected words have been consumed
  task automatic drain(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !pc_v) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: %0d words outstanding, pc_v=%0b, required 0 and 0", name, sb.size(), pc_v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; send_HB_up_pulse = 1'b0; time_elapsed = '0;
    in_v = '0; in_d = '0; pc_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_pc_v", pc_v, 0);
    check("rst_pc_code", pc_code, 0);
    check("rst_pc_payload", pc_payload, 0);
    check("rst_in_a", in_a, 0);

    // Single word on channel 2
    @(posedge clk); #1;
    set_ch(2, 37'h1_2345_6789);
    in_v = 4'b0100;
    push(8'd6, 24'h456789); push(8'd7, 24'h000123);
    @(negedge clk);
    check("single_ack_c0", in_a, 4'b0100);
    @(posedge clk);
    @(negedge clk);
    check("single_ack_c1", in_a, 4'b0000);
    @(posedge clk); #1 in_v = 4'b0000;
    drain("single_drain");

    // Fairness: all channels valid, rr pointer restarts at 0
    do_reset();
    set_ch(0, 37'h0_1111_1111); set_ch(1, 37'h1_2222_2222);
    set_ch(2, 37'h0_3333_3333); set_ch(3, 37'h1_FFFF_FFFF);
    push(8'd2, 24'h111111); push(8'd3, 24'h000011);
    push(8'd4, 24'h222222); push(8'd5, 24'h000122);
    push(8'd6, 24'h333333); push(8'd7, 24'h000033);
    push(8'd8, 24'hFFFFFF); push(8'd9, 24'h0001FF);
    @(posedge clk); #1 in_v = 4'hF;
    @(negedge clk);
    check("fair_first_ack", in_a, 4'b0001);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      if (k == 8) begin
        #1 in_v = 4'h0;
      end
      @(negedge clk);
      check("fair_nogap", pc_v, 1);
    end
    drain("fair_drain");

    // HB priority during a multi-chunk word
    @(posedge clk); #1;
    set_ch(1, 37'h0_ABCD_EF01);
    in_v = 4'b0010;
    push(8'd4, 24'hCDEF01); push(8'd5, 24'h0000AB);
    push(8'd1, 24'h000001); push(8'd0, 24'h000005);
    push(8'd4, 24'h000042); push(8'd5, 24'h000000);
    @(posedge clk); #1;
    send_HB_up_pulse = 1'b1; time_elapsed = 48'h000001_000005;
    set_ch(1, 37'h0_0000_0042);
    @(posedge clk); #1 send_HB_up_pulse = 1'b0;
    @(negedge clk);
    check("hb_noack_c2", in_a, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    check("hb_noack_c3", in_a, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    check("hb_then_data_ack", in_a, 4'b0010);
    @(posedge clk); #1 in_v = 4'b0000;
    drain("hb_drain");

    // Backpressure mid-word
    @(posedge clk); #1;
    set_ch(0, 37'h0_1234_5678);
    in_v = 4'b0001;
    push(8'd2, 24'h345678); push(8'd3, 24'h000012);
    push(8'd4, 24'h000777); push(8'd5, 24'h000000);
    @(posedge clk); #1;
    pc_a = 1'b0;
    set_ch(1, 37'h0_0000_0777);
    in_v = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_pc_v", pc_v, 1);
      check("bp_code", pc_code, 8'd2);
      check("bp_payload", pc_payload, 24'h345678);
      check("bp_in_a", in_a, 4'b0000);
      if (k < 4) @(posedge clk);
    end
    @(posedge clk); #1 pc_a = 1'b1;
    wait_ack(4'b0010, "bp_resume_ack");
    @(posedge clk); #1 in_v = 4'b0000;
    drain("bp_drain");

    // HB MSB elision (after reset so the first HB is always complete)
    do_reset();
    time_elapsed = 48'h000001_000005;
    send_HB_up_pulse = 1'b1;
    push(8'd1, 24'h000001); push(8'd0, 24'h000005);
    @(posedge clk); #1 send_HB_up_pulse = 1'b0;
    @(negedge clk);
    check("hb_lat_c1_pc_v", pc_v, 0);
    @(negedge clk);
    check("hb_lat_c2_pc_v", pc_v, 1);
    check("hb_lat_c2_code", pc_code, 8'd1);
    drain("elide_first_drain");
    @(posedge clk); #1;
    time_elapsed = 48'h000001_000006;
    send_HB_up_pulse = 1'b1;
`ifndef PC_SER_HB_MSB_ELIDE_EN
    push(8'd1, 24'h000001);
`endif
    push(8'd0, 24'h000006);
    @(posedge clk); #1 send_HB_up_pulse = 1'b0;
    drain("elide_second_drain");

    // Reset mid-word: chunk1 discarded, arbitration restarts at channel 0
    @(posedge clk); #1;
    set_ch(2, 37'h0_0000_0ABC);
    set_ch(0, 37'h0_0000_0001);
    set_ch(3, 37'h0_0000_0003);
    in_v = 4'b0100;
    push(8'd6, 24'h000ABC);
    @(negedge clk);
    check("rstmid_ack_ch2", in_a, 4'b0100);
    @(posedge clk); #1 in_v = 4'b0000;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_v = 4'b1001;
    push(8'd2, 24'h000001); push(8'd3, 24'h000000);
    @(negedge clk);
    check("rstmid_pc_v", pc_v, 0);
    check("rstmid_ack_ch0", in_a, 4'b0001);
    @(posedge clk); #1 in_v = 4'b0000;
    drain("rstmid_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
